// File: rtl/gpio_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner_if
//
// Purpose: bundles the per-bank GPIO signals exchanged between the pad/SoC side
// and the input conditioner.
//
// Signals (WIDTH bits unless noted):
//   io_pins_read         raw pad levels (asynchronous to the conditioner clock)
//   io_pins_writeEnable  1 = bit is an output, conditioner bypasses debounce
//   io_irqRiseMask       enables pending-set on an accepted rise
//   io_irqFallMask       enables pending-set on an accepted fall
//   io_irqClear          write-1-to-clear pulse for pending bits
//   io_read              conditioned levels
//   io_rise / io_fall    one-cycle pulses on accepted level changes
//   io_irqPending        sticky pending vector
//   io_irq               (1 bit) OR of io_irqPending
//
// Modports:
//   master  SoC / pad side (drives raw levels and control, receives results)
//   slave   conditioner side
// -----------------------------------------------------------------------------
interface gpio_input_conditioner_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] io_pins_read;
  logic [WIDTH-1:0] io_pins_writeEnable;
  logic [WIDTH-1:0] io_irqRiseMask;
  logic [WIDTH-1:0] io_irqFallMask;
  logic [WIDTH-1:0] io_irqClear;
  logic [WIDTH-1:0] io_read;
  logic [WIDTH-1:0] io_rise;
  logic [WIDTH-1:0] io_fall;
  logic [WIDTH-1:0] io_irqPending;
  logic             io_irq;

  modport master (
    output io_pins_read,
    output io_pins_writeEnable,
    output io_irqRiseMask,
    output io_irqFallMask,
    output io_irqClear,
    input  io_read,
    input  io_rise,
    input  io_fall,
    input  io_irqPending,
    input  io_irq
  );

  modport slave (
    input  io_pins_read,
    input  io_pins_writeEnable,
    input  io_irqRiseMask,
    input  io_irqFallMask,
    input  io_irqClear,
    output io_read,
    output io_rise,
    output io_fall,
    output io_irqPending,
    output io_irq
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
//
// Purpose: per-bit conditioner between GPIO pad read buffers and the SoC.
// Two-flop synchroniser, prescaled debounce, and (optionally) edge pulses with
// a sticky, maskable interrupt. Bits configured as outputs bypass debounce so
// the SoC reads back its own driven value after 3 clocks.
//
// Parameters:
//   WIDTH         pins per bank
//   TICK_DIV      debounce sample tick every TICK_DIV clocks (>= 1)
//   STABLE_TICKS  consecutive differing ticks needed to accept a level (1..255)
//
// Ports:
//   io_clock  system clock
//   io_reset  asynchronous, active-low reset
//   bus       gpio_input_conditioner_if.slave (pad levels, output enables,
//             masks, clear in; conditioned levels, edges, pending, irq out)
//
// Build option:
//   GPIO_COND_EDGE_IRQ_EN  when defined, edge pulses, pending register and
//                          io_irq exist; otherwise those outputs are tied to 0
//                          and mask/clear inputs are ignored.
// -----------------------------------------------------------------------------
module gpio_input_conditioner #(
  parameter int WIDTH        = 32,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                   io_clock,
  input  logic                   io_reset,
  gpio_input_conditioner_if.slave bus
);

  // Prescaler width; a divide of 1 still gets a 1-bit counter that stays 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    CNT_LAST   = 8'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] accept_vec;
  logic [PW-1:0]    presc_reg;
  logic [PW-1:0]    presc_next;
  logic             tick;

  // ---------------------------------------------------------------------------
  // Synchroniser and prescaler
  // ---------------------------------------------------------------------------
  assign tick = (presc_reg == PRESC_LAST);

  always_comb begin
    presc_next = presc_reg + PW'(1);
    if (tick) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      presc_reg <= '0;
    end else begin
      sync1_reg <= bus.io_pins_read;
      sync2_reg <= sync1_reg;
      presc_reg <= presc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce
  // A bit's accepted level only moves after STABLE_TICKS consecutive ticks on
  // which the synchronised level differs from it; any tick where it matches
  // restarts the count. Output bits track sync2 directly and keep the count at
  // zero, so switching back to input debounces from the current level.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [7:0] cnt_reg;
      logic [7:0] cnt_next;
      logic       stable_reg;
      logic       stable_next;
      logic       accept;

      always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        accept      = 1'b0;
        if (bus.io_pins_writeEnable[gi]) begin
          stable_next = sync2_reg[gi];
          cnt_next    = '0;
        end else if (tick) begin
          if (sync2_reg[gi] == stable_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_next = sync2_reg[gi];
            cnt_next    = '0;
            accept      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
        end
      end

      assign stable_vec[gi] = stable_reg;
      assign accept_vec[gi] = accept;
    end
  endgenerate

  assign bus.io_read = stable_vec;

  // ---------------------------------------------------------------------------
  // Edge pulses and sticky interrupt
  // ---------------------------------------------------------------------------
`ifdef GPIO_COND_EDGE_IRQ_EN
  // evt_*_reg mark the edge at which io_read changed; the visible pulse is one
  // stage later so it lands in the cycle after io_read moves.
  logic [WIDTH-1:0] evt_rise_reg;
  logic [WIDTH-1:0] evt_fall_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;

  // Set terms are OR'd after the clear so a coincident set wins.
  always_comb begin
    pending_next = (pending_reg & ~bus.io_irqClear)
                 | (evt_rise_reg & bus.io_irqRiseMask)
                 | (evt_fall_reg & bus.io_irqFallMask);
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      evt_rise_reg <= '0;
      evt_fall_reg <= '0;
      rise_reg     <= '0;
      fall_reg     <= '0;
      pending_reg  <= '0;
    end else begin
      // On acceptance the new level equals sync2, which gives the direction.
      evt_rise_reg <= accept_vec & sync2_reg;
      evt_fall_reg <= accept_vec & ~sync2_reg;
      rise_reg     <= evt_rise_reg;
      fall_reg     <= evt_fall_reg;
      pending_reg  <= pending_next;
    end
  end

  assign bus.io_rise       = rise_reg;
  assign bus.io_fall       = fall_reg;
  assign bus.io_irqPending = pending_reg;
  assign bus.io_irq        = |pending_reg;
`else
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{accept_vec, bus.io_irqRiseMask,
                                bus.io_irqFallMask, bus.io_irqClear};

  assign bus.io_rise       = '0;
  assign bus.io_fall       = '0;
  assign bus.io_irqPending = '0;
  assign bus.io_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
//
// Two instances share one set of inputs: dut1 (TICK_DIV=1) and dut3
// (TICK_DIV=3), both WIDTH=4, STABLE_TICKS=4. A reset table, hand-written
// corner sequences and a randomized phase against a window-based reference
// model. Edge/irq expectations follow GPIO_COND_EDGE_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;
  localparam int W  = 4;
  localparam int ST = 4;
`ifdef GPIO_COND_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [W-1:0] pins  = '0;
  logic [W-1:0] we    = '0;
  logic [W-1:0] rmask = '0;
  logic [W-1:0] fmask = '0;
  logic [W-1:0] clr   = '0;

  gpio_input_conditioner_if #(.WIDTH(W)) bus1 ();
  gpio_input_conditioner_if #(.WIDTH(W)) bus3 ();

  assign bus1.io_pins_read        = pins;
  assign bus1.io_pins_writeEnable = we;
  assign bus1.io_irqRiseMask      = rmask;
  assign bus1.io_irqFallMask      = fmask;
  assign bus1.io_irqClear         = clr;
  assign bus3.io_pins_read        = pins;
  assign bus3.io_pins_writeEnable = we;
  assign bus3.io_irqRiseMask      = rmask;
  assign bus3.io_irqFallMask      = fmask;
  assign bus3.io_irqClear         = clr;

  gpio_input_conditioner #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(ST)) dut1 (
    .io_clock (clk),
    .io_reset (rst_n),
    .bus      (bus1.slave)
  );

  gpio_input_conditioner #(.WIDTH(W), .TICK_DIV(3), .STABLE_TICKS(ST)) dut3 (
    .io_clock (clk),
    .io_reset (rst_n),
    .bus      (bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic logic [W-1:0] eg(input logic [W-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: a bit's level flips once the last ST tick samples of its
  // synchronised value all disagree with it (samples since reset or since it
  // was last an output). Ticks are every td-th clock counted since reset.
  // ---------------------------------------------------------------------------
  logic [W-1:0]  m_s1[2], m_s2[2], m_stab[2], m_evr[2], m_evf[2];
  logic [W-1:0]  m_rise[2], m_fall[2], m_pend[2];
  logic [ST-1:0] m_win[2][W];
  int            m_nv[2][W];
  int            m_cyc[2];

  task automatic model_update();
    int td;
    bit tick;
    logic [W-1:0] nr, nf;
    for (int d = 0; d < 2; d++) begin
      td = (d == 0) ? 1 : 3;
      if (!rst_n) begin
        m_s1[d] = '0; m_s2[d] = '0; m_stab[d] = '0; m_evr[d] = '0; m_evf[d] = '0;
        m_rise[d] = '0; m_fall[d] = '0; m_pend[d] = '0; m_cyc[d] = 0;
        for (int i = 0; i < W; i++) begin
          m_win[d][i] = '0;
          m_nv[d][i]  = 0;
        end
      end else begin
        tick = ((m_cyc[d] % td) == td - 1);
        m_cyc[d]++;
        nr = m_evr[d];
        nf = m_evf[d];
        m_evr[d] = '0;
        m_evf[d] = '0;
        for (int i = 0; i < W; i++) begin
          if (we[i]) begin
            m_stab[d][i] = m_s2[d][i];
            m_nv[d][i]   = 0;
          end else if (tick) begin
            m_win[d][i] = {m_win[d][i][ST-2:0], m_s2[d][i]};
            m_nv[d][i]++;
            if (m_nv[d][i] >= ST && m_win[d][i] == {ST{~m_stab[d][i]}}) begin
              m_stab[d][i] = ~m_stab[d][i];
              if (m_stab[d][i]) m_evr[d][i] = 1'b1;
              else              m_evf[d][i] = 1'b1;
              m_nv[d][i] = 0;
            end
          end
        end
        m_pend[d] = (m_pend[d] & ~clr) | (nr & rmask) | (nf & fmask);
        m_rise[d] = nr;
        m_fall[d] = nf;
        m_s2[d]   = m_s1[d];
        m_s1[d]   = pins;
      end
    end
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs read at +1.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cmp_model(input int d);
    logic [W-1:0] r, ri, fa, pe;
    logic         iq;
    if (d == 0) begin
      r = bus1.io_read; ri = bus1.io_rise; fa = bus1.io_fall; pe = bus1.io_irqPending; iq = bus1.io_irq;
    end else begin
      r = bus3.io_read; ri = bus3.io_rise; fa = bus3.io_fall; pe = bus3.io_irqPending; iq = bus3.io_irq;
    end
    chk($sformatf("rnd_read_d%0d", d), r, m_stab[d]);
    chk($sformatf("rnd_rise_d%0d", d), ri, eg(m_rise[d]));
    chk($sformatf("rnd_fall_d%0d", d), fa, eg(m_fall[d]));
    chk($sformatf("rnd_pend_d%0d", d), pe, eg(m_pend[d]));
    chk($sformatf("rnd_irq_d%0d", d), {3'b0, iq}, {3'b0, EDGE_EN && (m_pend[d] != '0)});
  endtask

  typedef struct {
    logic         rst_n;
    logic [W-1:0] pins;
    logic [W-1:0] e_read;
    logic [W-1:0] e_rise;
    logic [W-1:0] e_pend;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bseq[5];
    logic ph[24];
    int n;
    int e;

    // Reset table: pins high through reset, release, then edges 1..9.
    for (int r = 0; r < 12; r++) begin
      e = r - 2;
      tbl[r].rst_n  = (r >= 3);
      tbl[r].pins   = 4'hF;
      tbl[r].e_read = (r >= 3 && e >= 6) ? 4'hF : 4'h0;
      tbl[r].e_rise = (r >= 3 && e == 7) ? 4'hF : 4'h0;
      tbl[r].e_pend = (r >= 3 && e >= 7) ? 4'hF : 4'h0;
    end
    rmask = 4'hF;
    fmask = 4'hF;
    for (int r = 0; r < 12; r++) begin
      rst_n = tbl[r].rst_n;
      pins  = tbl[r].pins;
      step();
      chk($sformatf("rst_read[%0d]", r), bus1.io_read, tbl[r].e_read);
      chk($sformatf("rst_rise[%0d]", r), bus1.io_rise, eg(tbl[r].e_rise));
      chk($sformatf("rst_fall[%0d]", r), bus1.io_fall, 4'h0);
      chk($sformatf("rst_pend[%0d]", r), bus1.io_irqPending, eg(tbl[r].e_pend));
      chk($sformatf("rst_irq[%0d]", r), {3'b0, bus1.io_irq}, {3'b0, EDGE_EN && tbl[r].e_pend != 0});
    end

    // Bounce on bit0: 1,1,1,0,1 then held 1.
    pins = '0; rmask = '0; fmask = '0;
    repeat (8) step();
    clr = 4'hF; step(); clr = '0; step();
    chk("bounce_pre_read", bus1.io_read, 4'h0);
    bseq = '{1, 1, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      pins[0] = bseq[k][0];
      step();
      chk($sformatf("bounce_early_e%0d", k + 1), {3'b0, bus1.io_read[0]}, 4'h0);
    end
    for (int ed = 6; ed <= 15; ed++) begin
      step();
      chk($sformatf("bounce_read_e%0d", ed), {3'b0, bus1.io_read[0]}, {3'b0, ed >= 10});
      chk($sformatf("bounce_rise_e%0d", ed), {3'b0, bus1.io_rise[0]}, eg({3'b0, ed == 11}));
    end

    // Interrupt: rise mask on bit0, set/clear interplay.
    pins = '0; rmask = 4'b0001; fmask = '0;
    repeat (8) step();
    clr = 4'hF; step(); clr = '0; step();
    chk("irq_pre_pend", bus1.io_irqPending, 4'h0);
    pins[0] = 1'b1;
    repeat (6) step();
    chk("irq_read_rise", bus1.io_read, 4'b0001);
    step();
    chk("irq_rise_pulse", bus1.io_rise, eg(4'b0001));
    chk("irq_pend_set", bus1.io_irqPending, eg(4'b0001));
    chk("irq_line_set", {3'b0, bus1.io_irq}, {3'b0, EDGE_EN});
    pins[0] = 1'b0;
    repeat (8) step();
    chk("irq_fall_unmasked", bus1.io_irqPending, eg(4'b0001));
    pins[0] = 1'b1;
    repeat (6) step();
    clr = 4'b0001;
    step();
    chk("irq_set_wins_pulse", bus1.io_rise, eg(4'b0001));
    chk("irq_set_wins", bus1.io_irqPending, eg(4'b0001));
    clr = '0;
    step();
    chk("irq_hold", bus1.io_irqPending, eg(4'b0001));
    clr = 4'b0001;
    step();
    clr = '0;
    chk("irq_clear_pend", bus1.io_irqPending, 4'h0);
    chk("irq_clear_line", {3'b0, bus1.io_irq}, 4'h0);

    // Bypass on bit2: toggles every 4 cycles, read follows 3 clocks later.
    pins = '0; rmask = 4'hF; fmask = 4'hF;
    repeat (8) step();
    we = 4'b0100;
    for (int k = 0; k < 24; k++) begin
      pins[2] = ((k / 4) % 2) == 0;
      ph[k] = pins[2];
      step();
      chk($sformatf("bypass_read_e%0d", k + 1), {3'b0, bus1.io_read[2]},
          {3'b0, (k + 1 >= 3) ? ph[k - 2] : 1'b0});
      chk($sformatf("bypass_edge_e%0d", k + 1), {2'b0, bus1.io_rise[2], bus1.io_fall[2]}, 4'h0);
    end
    we = '0; pins = '0;
    repeat (40) step();

    // Prescale on dut3: latency bounded by tick phase, 5-clock pulse rejected.
    chk("presc_pre_read", bus3.io_read, 4'h0);
    pins[1] = 1'b1;
    n = 0;
    while (bus3.io_read[1] == 1'b0 && n < 30) begin
      step();
      n++;
    end
    chk_range("presc_latency", n, 12, 14);
    pins[1] = 1'b0;
    repeat (5) step();
    pins[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("presc_glitch_%0d", k), {3'b0, bus3.io_read[1]}, 4'b0001);
    end

    // Randomized phase against the model, both instances.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(7) == 0) pins[i] = ~pins[i];
      end
      if ($urandom_range(31) == 0) we = W'($urandom_range(15));
      rmask = W'($urandom_range(15));
      fmask = W'($urandom_range(15));
      clr   = ($urandom_range(3) == 0) ? W'($urandom_range(15)) : '0;
      if (c == 700) rst_n = 1'b0;
      if (c == 703) rst_n = 1'b1;
      step();
      cmp_model(0);
      cmp_model(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
